// File: rtl/updown_pkg.sv
// Shared types and elaboration helpers for the up/down counter family.
package updown_pkg;

    // Behaviour when a step would leave the legal range 0..MAX_VAL.
    typedef enum logic [0:0] {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // True when MAX_VAL fits in WIDTH bits and 1 <= STEP <= MAX_VAL.
    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned max_val,
                                     input int unsigned step);
        bit fits;
        if (width >= 32) begin
            fits = 1'b1;
        end else begin
            fits = (max_val < (32'd1 << width));
        end
        return fits && (step >= 1) && (step <= max_val);
    endfunction

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count and overflow/underflow computation for one enabled step.
module updown_next_calc
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned STEP    = 1,
    parameter mode_e       MODE    = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_count,
    output logic             ovf,
    output logic             udf
);

    // One extra bit so count+STEP and count+MAX_VAL+1 never truncate.
    localparam logic [WIDTH:0] MaxExt  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] StepExt = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] Modulus = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] sum_up;

    // Step in the requested direction, wrapping or saturating at the limits.
    always_comb begin
        count_ext  = {1'b0, count};
        sum_up     = count_ext + StepExt;
        next_count = count;
        ovf        = 1'b0;
        udf        = 1'b0;
        if (up_down) begin
            if (sum_up > MaxExt) begin
                ovf        = 1'b1;
                next_count = (MODE == MODE_SAT) ? WIDTH'(MAX_VAL) : WIDTH'(sum_up - Modulus);
            end else begin
                next_count = WIDTH'(sum_up);
            end
        end else begin
            if (count_ext < StepExt) begin
                udf        = 1'b1;
                next_count = (MODE == MODE_SAT) ? '0
                                                : WIDTH'(count_ext + Modulus - StepExt);
            end else begin
                next_count = WIDTH'(count_ext - StepExt);
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with clear, load, wrap/saturate modes and event flags.
module updown_counter_param
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned STEP    = 1,
    parameter mode_e       MODE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up_down,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             udf,
    output logic             ovf_sticky,
    output logic             udf_sticky
);

    if (!params_ok(WIDTH, MAX_VAL, STEP)) begin : gen_bad_params
        $error("updown_counter_param: need MAX_VAL < 2**WIDTH and 1 <= STEP <= MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             udf_sticky_q, udf_sticky_d;

    logic [WIDTH-1:0] step_count;
    logic             step_ovf;
    logic             step_udf;

    updown_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP    (STEP),
        .MODE    (MODE)
    ) u_next_calc (
        .count      (count_q),
        .up_down    (up_down),
        .next_count (step_count),
        .ovf        (step_ovf),
        .udf        (step_udf)
    );

    // Next state: clear > load > enable; pulses only come from an enabled step.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MaxCnt) ? MaxCnt : load_val;
        end else if (enable) begin
            count_d = step_count;
            ovf_d   = step_ovf;
            udf_d   = step_udf;
        end
        // A new event wins over a same-cycle flag_clr.
        ovf_sticky_d = ovf_d | (ovf_sticky_q & ~flag_clr);
        udf_sticky_d = udf_d | (udf_sticky_q & ~flag_clr);
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            udf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            ovf_sticky_q <= ovf_sticky_d;
            udf_sticky_q <= udf_sticky_d;
        end
    end

    assign count      = count_q;
    assign at_max     = (count_q == MaxCnt);
    assign at_min     = (count_q == '0);
    assign ovf        = ovf_q;
    assign udf        = udf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign udf_sticky = udf_sticky_q;

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 The block SHALL have one clock, `clk`; reset `rst` is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- WIDTH, default 4: counter width in bits.
- MAX_VAL, default 2**WIDTH-1: terminal count; the legal range is 0..MAX_VAL.
- STEP, default 1: increment/decrement per enabled cycle.
- MODE, default MODE_WRAP: MODE_WRAP or MODE_SAT.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous soft clear of count.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  parallel load value.
- enable  in  1  count enable.
- up_down  in  1  1 = count up, 0 = count down.
- flag_clr  in  1  clears the sticky flags.
- count  out  WIDTH  registered count.
- at_max  out  1  count == MAX_VAL (combinational from count).
- at_min  out  1  count == 0 (combinational from count).
- ovf  out  1  registered one-cycle pulse on an up step past MAX_VAL.
- udf  out  1  registered one-cycle pulse on a down step below 0.
- ovf_sticky  out  1  set by ovf, held until cleared.
- udf_sticky  out  1  set by udf, held until cleared.

Function
REQ-004 Per-edge priority SHALL be: rst > clear > load > enable; with enable=0 and no other action, count holds.
REQ-005 clear SHALL set count to 0 on the next edge without affecting the sticky flags, and SHALL NOT raise ovf or udf.
REQ-006 load SHALL set count to min(load_val, MAX_VAL) on the next edge; ovf and udf SHALL be 0 that cycle.
REQ-007 When enabled with up_down=1 and count+STEP <= MAX_VAL, count SHALL become count+STEP.
REQ-008 When enabled with up_down=0 and count >= STEP, count SHALL become count-STEP.
REQ-009 Next-value arithmetic SHALL use WIDTH+1 bits, so no intermediate truncates.
REQ-010 Up overflow (count+STEP > MAX_VAL):
- MODE_WRAP: count SHALL become count+STEP-(MAX_VAL+1).
- MODE_SAT: count SHALL become MAX_VAL.
- In both modes, ovf SHALL be 1 in the cycle the new count is visible.
REQ-011 Down underflow (count < STEP):
- MODE_WRAP: count SHALL become count+(MAX_VAL+1)-STEP.
- MODE_SAT: count SHALL become 0.
- In both modes, udf SHALL be 1 in the cycle the new count is visible.
REQ-012 In MODE_SAT, each enabled cycle that attempts to step past a limit SHALL pulse ovf/udf again while count is held.
REQ-013 ovf and udf SHALL be registered and aligned with the count update, i.e. zero added latency.
REQ-014 Sticky flags SHALL set on their pulse and clear on flag_clr; if flag_clr and a new event occur in the same cycle, set SHALL win.
REQ-015 A direction change SHALL take effect on the next enabled edge, with no dead cycle.

Reset
REQ-016 On rst=1 at a rising edge:
- count, ovf, udf, ovf_sticky and udf_sticky SHALL be 0.
- at_min SHALL be 1.
- at_max SHALL be 1 only if MAX_VAL = 0.
REQ-017 rst asserted mid-count SHALL override clear, load and enable in the same cycle.
REQ-018 No output SHALL change asynchronously to clk.

Structure
REQ-019 Shared package `updown_pkg` SHALL hold the MODE_WRAP/MODE_SAT mode enum and a parameter-check helper.
REQ-020 Elaboration SHALL fail unless MAX_VAL < 2**WIDTH and 1 <= STEP <= MAX_VAL.
REQ-021 Next-value and overflow/underflow computation SHALL sit in one combinational sub-module, `updown_next_calc`.
REQ-022 All registers SHALL be in the top module.

Verification (WIDTH=4, MAX_VAL=9, STEP=1, MODE_WRAP unless stated)
REQ-023 rst=1 for 2 cycles with enable=1, up_down=1:
- count=0, at_min=1, all flags 0.
- After release, count reads 1, 2, … on successive edges.
REQ-024 Up for 12 enabled cycles from 0:
- count = 1..9, 0, 1, 2.
- ovf=1 only on the 9->0 cycle; ovf_sticky=1 thereafter.
- flag_clr then drives ovf_sticky to 0.
REQ-025 Down from 0: count=9, udf=1 for one cycle. With MODE_SAT, down from 0 for 3 cycles: count stays 0 and udf=1 each cycle.
REQ-026 load with load_val=12: count=9, at_max=1. Then load_val=5 with load=1, enable=1, up_down=1 in the same cycle: count=5 (load wins).
REQ-027 STEP=3, MODE_WRAP:
- Up from 8: count=1 with ovf=1.
- Down from 1: count=8 with udf=1.
- MODE_SAT up from 8: count=9 with ovf=1.
REQ-028 Reset and same-cycle events:
- rst at count=5 with ovf_sticky=1 and enable=1: count=0, ovf_sticky=0 on the next edge.
- clear with enable=1: count=0, no pulse.
- flag_clr with a same-cycle ovf: ovf_sticky stays 1.
